// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and request-decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // Stores only have signed-width codes; loads add the unsigned variants.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return !(f3 inside {F3_B, F3_H, F3_W});
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         F3_H, F3_HU: return lo[0];
         F3_W:        return lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with sign/zero extension and
// read-modify-write merge of byte/halfword stores into a fetched word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Halfwords always use lane addr[1]; words always use lane 0, so
   // unchecked misaligned accesses land on a defined lane.
   always_comb begin
      lane_b = rword[{addr_lo, 3'b000} +: 8];
      lane_h = rword[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_data = {24'd0, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_data = {16'd0, lane_h};
         default: load_data = rword;
      endcase
   end

   // Merge store data into the captured word; other lanes pass through.
   always_comb begin
      store_word = rword;
      case (funct3)
         F3_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM in front of a word RAM.
// Sub-word stores are done as read-modify-write.
module lsu
   import lsu_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_t      state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic        err_q;

   logic        req_err;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign req_err = f3_illegal(req_we, req_funct3) ||
                    (CHECK_ALIGN && f3_misaligned(req_funct3, req_addr[1:0]));
   assign accept  = req_valid && req_ready;

   lsu_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .rword      (word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // State register, request latch on accept and read-word capture in RD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         word_q   <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
         end
         if (state_q == RD) word_q <= mem_rd;
      end
   end

   // Next-state decode and per-state handshake/RAM strobes.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)                          state_d = RESP;
               else if (req_we && req_funct3 == F3_W) state_d = WR;
               else                                  state_d = RD;
            end
         end
         RD:      state_d = we_q ? WR : RESP;
         WR: begin
            mem_we  = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wd     = mem_we ? store_word : 32'd0;
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu against a 128-byte little-endian RAM model.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [7:0] ram [128];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nwe;
      logic [31:0] addr;
      logic [31:0] wd;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   we_cnt = 0;
   bit   done = 1'b0;

   lsu #(.CHECK_ALIGN(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: combinational read, posedge write.
   assign mem_rd = {ram[{mem_addr[6:2], 2'd3}], ram[{mem_addr[6:2], 2'd2}],
                    ram[{mem_addr[6:2], 2'd1}], ram[{mem_addr[6:2], 2'd0}]};

   always @(posedge clk) begin
      if (mem_we) begin
         ram[{mem_addr[6:2], 2'd0}] <= mem_wd[7:0];
         ram[{mem_addr[6:2], 2'd1}] <= mem_wd[15:8];
         ram[{mem_addr[6:2], 2'd2}] <= mem_wd[23:16];
         ram[{mem_addr[6:2], 2'd3}] <= mem_wd[31:24];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Monitor: check RAM writes and pop the scoreboard on each response.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) begin
            we_cnt++;
            if (sb_q.size() > 0) begin
               check("wr_addr", mem_addr, {sb_q[0].addr[31:2], 2'b00});
               check("wr_data", mem_wd, sb_q[0].wd);
            end
         end
         if (resp_valid) begin
            check("resp_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               check("rdata", resp_rdata, mon_e.rdata);
               check("err", {31'd0, resp_err}, {31'd0, mon_e.err});
               check("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
               check("we_cycles", 32'(we_cnt), 32'(mon_e.nwe));
               done = 1'b1;
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input int nwe, input logic [31:0] exp_wd);
      int t;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      sb_q.push_back('{exp_rd, exp_err, lat, nwe, a, exp_wd});
      done    = 1'b0;
      acc_cyc = cyc;
      we_cnt  = 0;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("resp_seen", {31'd0, done}, 32'd1);
      if (!done) sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) ram[i] = 8'h00;
      ram[0] = 8'h10;
      ram[1] = 8'h32;
      ram[2] = 8'h54;
      ram[3] = 8'h76;

      #12;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //    we    f3     addr   wdata         exp_rdata     err  lat nwe exp_wd
      issue(1'b0, F3_W,  32'd0, 32'd0,        32'h76543210, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_B,  32'd3, 32'd0,        32'h00000076, 1'b0, 2, 0, 32'd0);
      issue(1'b1, F3_B,  32'd1, 32'h000000AB, 32'd0,        1'b0, 3, 1, 32'h7654AB10);
      issue(1'b0, F3_W,  32'd0, 32'd0,        32'h7654AB10, 1'b0, 2, 0, 32'd0);
      issue(1'b1, F3_B,  32'd3, 32'h00000080, 32'd0,        1'b0, 3, 1, 32'h8054AB10);
      issue(1'b0, F3_B,  32'd3, 32'd0,        32'hFFFFFF80, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_BU, 32'd3, 32'd0,        32'h00000080, 1'b0, 2, 0, 32'd0);
      issue(1'b1, F3_H,  32'd2, 32'h1234BEEF, 32'd0,        1'b0, 3, 1, 32'hBEEFAB10);
      issue(1'b0, F3_HU, 32'd2, 32'd0,        32'h0000BEEF, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_H,  32'd2, 32'd0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_W,  32'd0, 32'd0,        32'hBEEFAB10, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_H,  32'd1, 32'd0,        32'd0,        1'b1, 1, 0, 32'd0);
      issue(1'b1, F3_W,  32'd2, 32'hDEADBEEF, 32'd0,        1'b1, 1, 0, 32'd0);
      issue(1'b0, 3'b011, 32'd0, 32'd0,       32'd0,        1'b1, 1, 0, 32'd0);
      issue(1'b1, F3_BU, 32'd0, 32'h000000FF, 32'd0,        1'b1, 1, 0, 32'd0);
      issue(1'b1, F3_W,  32'd8, 32'hAABBCCDD, 32'd0,        1'b0, 2, 1, 32'hAABBCCDD);
      issue(1'b0, F3_W,  32'd8, 32'd0,        32'hAABBCCDD, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_H,  32'd8, 32'd0,        32'hFFFFCCDD, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_HU, 32'd10, 32'd0,       32'h0000AABB, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_B,  32'd9, 32'd0,        32'hFFFFFFCC, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_BU, 32'd10, 32'd0,       32'h000000BB, 1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_W,  32'd0, 32'd0,        32'hBEEFAB10, 1'b0, 2, 0, 32'd0);

      // Abort a SW to address 4 by resetting while it sits in WR.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'd4;
      req_wdata  = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("abort_we_high", {31'd0, mem_we}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_we_drop", {31'd0, mem_we}, 32'd0);
      check("abort_resp", {31'd0, resp_valid}, 32'd0);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_addr", mem_addr, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("abort_ram", {ram[7], ram[6], ram[5], ram[4]}, 32'd0);
      issue(1'b0, F3_W,  32'd4, 32'd0,        32'd0,        1'b0, 2, 0, 32'd0);
      issue(1'b0, F3_W,  32'd0, 32'd0,        32'hBEEFAB10, 1'b0, 2, 0, 32'd0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1: when 1, misaligned halfword and word accesses return an error instead of touching memory.
REQ-002 SHALL have port clk  input  1  single clock; memory writes and all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU request present.
REQ-005 SHALL have port req_ready  output  1  LSU can accept a request; high only in IDLE.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  misaligned access or illegal funct3, qualified by resp_valid.
REQ-013 SHALL have port mem_addr  output  32  word-aligned RAM address ({req_addr[31:2],2'b00}).
REQ-014 SHALL have port mem_we  output  1  RAM write enable, sampled by the RAM on posedge clk.
REQ-015 SHALL have port mem_wd  output  32  RAM write data, little-endian.
REQ-016 SHALL have port mem_rd  input  32  RAM read data, combinational from mem_addr, little-endian (byte at addr in bits 7:0).

Function
REQ-017 SHALL accept a request on a posedge where req_valid && req_ready; all request fields SHALL be latched then, and the inputs are don't-care afterward.
REQ-018 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-019 SHALL transition IDLE->RD for loads, SB and SH; IDLE->WR for SW; IDLE->RESP for errors.
REQ-020 SHALL transition RD->RESP for loads, RD->WR for SB/SH, WR->RESP, and RESP->IDLE unconditionally.
REQ-021 In RD, SHALL drive mem_we=0 and capture mem_rd into an internal word register at the cycle-end posedge.
REQ-022 In WR, SHALL drive mem_we=1.
REQ-023 In WR for SW, mem_wd SHALL equal req_wdata.
REQ-024 In WR for SB/SH, mem_wd SHALL be the captured word with the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]; other lanes are unchanged.
REQ-025 mem_we SHALL be 0 in every state other than WR.
REQ-026 In all other states, mem_addr SHALL hold the latched aligned address and mem_wd SHALL be 0.
REQ-027 Latency from the accept edge to resp_valid: 2 cycles for a load, 2 for SW, 3 for SB/SH, 1 for an error.
REQ-028 resp_valid SHALL be high only in RESP.
REQ-029 There is no response back-pressure; the next request is acceptable the cycle after RESP.
REQ-030 Load extraction: LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, lane selected by addr[1:0].
REQ-031 Misalignment SHALL be LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; any other funct3 is illegal.
REQ-032 When CHECK_ALIGN=0, a misaligned halfword SHALL use lane addr[1] and a misaligned word SHALL use lane 0, with no error.
REQ-033 An error response SHALL never assert mem_we.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0, and clear the latched request and captured word.
REQ-035 Reset asserted during RD/WR SHALL abort the access; no write SHALL occur on any later edge and no response SHALL issue.
REQ-036 After rst_n deassertion, a request SHALL be accepted on the first posedge.

Structure
REQ-037 A shared package lsu_pkg SHALL hold the funct3 constants and the state enum (IDLE, RD, WR, RESP).
REQ-038 A combinational sub-module lsu_align SHALL perform lane extraction with sign/zero extension and store-lane merge; the FSM stays in lsu.

Verification (lsu instantiated against ram, MEM_SIZE=128, bytes 0..3 preloaded 10 32 54 76)
REQ-039 LW addr 0 -> resp_valid 2 cycles after accept, resp_rdata=0x76543210, resp_err=0.
REQ-040 LB addr 3 -> resp_rdata=0x00000076; after SB addr 3 data 0x80, LB addr 3 -> 0xFFFFFF80 and LBU addr 3 -> 0x00000080.
REQ-041 SB addr 1 wdata 0x000000AB -> mem_we high exactly one cycle, then LW addr 0 returns 0x7654AB10 (with byte 3 still 0x76).
REQ-042 SH addr 2 wdata 0xBEEF, then LHU addr 2 -> 0x0000BEEF and LH addr 2 -> 0xFFFFBEEF.
REQ-043 LH addr 1 with CHECK_ALIGN=1 -> resp_valid and resp_err 1 cycle after accept, mem_we never high, resp_rdata=0.
REQ-044 SW addr 4 wdata 0x12345678 with rst_n pulsed low during WR -> mem_we drops immediately, no resp_valid, and a later LW addr 4 does not return 0x12345678.
